// File: rtl/instr_fetch_unit.sv
// Program counter owner and instruction ROM driver; optional PC range check via PC_BOUNDS_CHECK_EN.
// Latency: i_bus shows ROM[pc] the cycle after each increment/load; one BOOT cycle after reset.
// Backpressure: none; control inputs act every RUN cycle, ignored in BOOT and HALT.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          ADDR_W     = 16,
  parameter int          PROG_WORDS = 65536
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_increment,
  input  logic              pc_load,
  input  logic [15:0]       d_bus,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [15:0]       rom_data,
  output logic [15:0]       i_bus,
  output logic              i_valid,
  output logic [15:0]       pc,
  output logic [15:0]       jump_count,
  output logic              fault
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

`ifdef PC_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  localparam logic [16:0] PROG_LIM = 17'(PROG_WORDS);

  state_t      state, state_nxt;
  logic [15:0] pc_q, pc_cand, pc_d, jc_q;
  logic        oob, jc_inc;

  // Load wins over increment; increment wraps naturally at 16 bits.
  always_comb begin
    pc_cand = pc_q;
    if (pc_load)
      pc_cand = d_bus;
    else if (pc_increment)
      pc_cand = pc_q + 16'd1;
  end

  assign oob = BOUNDS_EN && ({1'b0, pc_cand} >= PROG_LIM);

  always_comb begin
    state_nxt = state;
    pc_d      = pc_q;
    jc_inc    = 1'b0;
    case (state)
      BOOT: state_nxt = RUN;
      RUN: begin
        if (oob) begin
          state_nxt = HALT;
        end else begin
          pc_d   = pc_cand;
          jc_inc = pc_load;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      pc_q  <= RESET_PC;
      jc_q  <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc_q  <= pc_d;
      if (jc_inc && (jc_q != 16'hFFFF))
        jc_q <= jc_q + 16'd1;
    end
  end

  // The ROM registers the address of the PC being committed, so its data lines up with pc next cycle.
  assign rom_addr   = pc_d[ADDR_W-1:0];
  assign rom_en     = (state != HALT);
  assign i_valid    = (state == RUN);
  assign i_bus      = i_valid ? rom_data : 16'hFFFF;
  assign pc         = pc_q;
  assign jump_count = jc_q;

`ifdef PC_BOUNDS_CHECK_EN
  assign fault = (state == HALT);
`else
  assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed vector table, corner sequences, randomized run vs model.
module tb_instr_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;
`ifdef PC_BOUNDS_CHECK_EN
  localparam int PW = 256;
  localparam bit BC = 1'b1;
`else
  localparam int PW = 65536;
  localparam bit BC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_increment = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] d_bus = 16'h0000;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [15:0] rom_data;
  logic [15:0] i_bus;
  logic        i_valid;
  logic [15:0] pc;
  logic [15:0] jump_count;
  logic        fault;

  instr_fetch_unit #(.RESET_PC(RST_PC), .ADDR_W(16), .PROG_WORDS(PW)) dut (
    .clk(clk), .rst_n(rst_n), .pc_increment(pc_increment), .pc_load(pc_load),
    .d_bus(d_bus), .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
    .i_bus(i_bus), .i_valid(i_valid), .pc(pc), .jump_count(jump_count), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    return (a ^ 16'hC3A5) + {a[7:0], a[15:8]};
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= rom_word(rom_addr);

  int checks = 0;
  int errors = 0;

  logic [15:0] m_pc, m_jc;
  bit          m_boot, m_halt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic vld;
    vld = !m_boot && !m_halt;
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " jump_count"}, jump_count, m_jc);
    chk({tag, " i_valid"}, i_valid, vld);
    chk({tag, " i_bus"}, i_bus, vld ? rom_word(m_pc) : 16'hFFFF);
    chk({tag, " fault"}, fault, m_halt);
    chk({tag, " rom_en"}, rom_en, !m_halt);
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_jc = 16'h0000; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  task automatic model_clock(input logic inc, input logic load, input logic [15:0] d);
    logic [15:0] nxt;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_halt) begin
      nxt = load ? d : (inc ? m_pc + 16'd1 : m_pc);
      if (BC && int'(nxt) >= PW) begin
        m_halt = 1'b1;
      end else begin
        m_pc = nxt;
        if (load && m_jc != 16'hFFFF) m_jc = m_jc + 16'd1;
      end
    end
  endtask

  // Called at a falling edge; drives, clocks the DUT and the model, samples at the next falling edge.
  task automatic step(input logic inc, input logic load, input logic [15:0] d,
                      input bit do_chk, input string tag);
    pc_increment = inc; pc_load = load; d_bus = d;
    @(posedge clk);
    model_clock(inc, load, d);
    @(negedge clk);
    if (do_chk) check_model(tag);
  endtask

  // Asserts reset between clock edges and checks that state cleared without an edge.
  task automatic apply_reset(input bit async_chk);
    #2;
    rst_n = 1'b0; pc_increment = 1'b0; pc_load = 1'b0;
    #1;
    model_reset();
    if (async_chk) begin
      chk("async pc", pc, RST_PC);
      chk("async jump_count", jump_count, 16'h0000);
      chk("async i_valid", i_valid, 1'b0);
      chk("async i_bus", i_bus, 16'hFFFF);
      chk("async rom_addr", rom_addr, RST_PC);
      chk("async rom_en", rom_en, 1'b1);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_model("boot");
  endtask

  typedef struct {
    logic        inc;
    logic        load;
    logic [15:0] d;
    logic [15:0] exp_pc;
    logic [15:0] exp_jc;
  } vec_t;

  vec_t vt[9];

  initial begin
    logic       r_inc, r_load;
    logic [15:0] r_d;

    vt[0] = '{1'b1, 1'b0, 16'h0000, 16'h0001, 16'h0000};
    vt[1] = '{1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000};
    vt[2] = '{1'b1, 1'b1, 16'h0040, 16'h0040, 16'h0001};
    vt[3] = '{1'b0, 1'b1, 16'h0040, 16'h0040, 16'h0002};
    vt[4] = '{1'b1, 1'b0, 16'h0000, 16'h0041, 16'h0002};
    vt[5] = '{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0003};
    vt[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0003};
    vt[7] = '{1'b1, 1'b1, 16'h0020, 16'h0020, 16'h0004};
    vt[8] = '{1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0005};

    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_model("por boot");

    // Inputs during BOOT must be ignored; first RUN cycle shows ROM[0].
    step(1'b1, 1'b1, 16'h0033, 1'b1, "boot_ignore");
    chk("first word", i_bus, 16'h1234);
    chk("first pc", pc, 16'h0000);

`ifndef PC_BOUNDS_CHECK_EN
    for (int i = 0; i < 9; i++) begin
      step(vt[i].inc, vt[i].load, vt[i].d, 1'b0, "");
      chk($sformatf("vec%0d pc", i), pc, vt[i].exp_pc);
      chk($sformatf("vec%0d jump_count", i), jump_count, vt[i].exp_jc);
      chk($sformatf("vec%0d i_valid", i), i_valid, 1'b1);
      chk($sformatf("vec%0d i_bus", i), i_bus, rom_word(vt[i].exp_pc));
      chk($sformatf("vec%0d fault", i), fault, 1'b0);
    end
    apply_reset(1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, "reboot");
`else
    step(1'b0, 1'b1, 16'h0100, 1'b1, "oob");
    chk("oob pc", pc, 16'h0000);
    chk("oob fault", fault, 1'b1);
    chk("oob i_valid", i_valid, 1'b0);
    chk("oob rom_en", rom_en, 1'b0);
    chk("oob i_bus", i_bus, 16'hFFFF);
    step(1'b1, 1'b1, 16'h0010, 1'b1, "halt_hold");
    chk("halt_hold pc", pc, 16'h0000);
    apply_reset(1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1, "reboot");
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset(1'b1);
      end else begin
        r_inc  = 1'($urandom_range(0, 1));
        r_load = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 7) == 0)
          r_d = m_pc;
        else if (BC && $urandom_range(0, 15) != 0)
          r_d = 16'($urandom_range(0, PW - 1));
        else
          r_d = 16'($urandom);
        step(r_inc, r_load, r_d, 1'b1, "rand");
      end
    end

    // Saturation of the jump counter using same-PC loads.
    apply_reset(1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b1, "sat start");
    for (int i = 0; i < 65534; i++)
      step(1'b0, 1'b1, 16'h0000, (i % 8192) == 0, "sat");
    chk("sat pre", jump_count, 16'hFFFE);
    step(1'b0, 1'b1, 16'h0000, 1'b1, "sat reach");
    chk("sat reach", jump_count, 16'hFFFF);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 16'h0000, 1'b1, "sat hold");
    chk("sat hold", jump_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
